bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 14 +
 rtl/bus_arbiter_rr_pick.sv | 21 ++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encoding and one-hot grant constants.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Two-requester round-robin picker: a sole requester wins, a tie goes to the
// master that was not served last.
module rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_m1,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = GNT_NONE;
    case (i_req)
      2'b01:   o_gnt = GNT_M0;
      2'b10:   o_gnt = GNT_M1;
      2'b11:   o_gnt = i_last_m1 ? GNT_M0 : GNT_M1;
      default: o_gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a single slave port.
// Define BUS_ARBITER_TIMEOUT_EN to add the slave-ack watchdog (m*_err_o).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  arb_state_e r_state, w_next;
  logic       r_last_m1;
  logic [1:0] w_pick;
  logic       w_timeout;

  rr_pick u_pick (
    .i_req     ({m1_cyc_i, m0_cyc_i}),
    .i_last_m1 (r_last_m1),
    .o_gnt     (w_pick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_next != ST_IDLE)
        r_last_m1 <= (w_next == ST_GRANT1);
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] r_to_cnt;

  // Idle clears the count, so every grant entry starts from zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_to_cnt <= '0;
    else if (r_state == ST_IDLE || s_ack_i || w_timeout)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + 8'd1;
  end

  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_LIMIT);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    grant_o  = GNT_NONE;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick == GNT_M0)      w_next = ST_GRANT0;
        else if (w_pick == GNT_M1) w_next = ST_GRANT1;
      end
      ST_GRANT0: begin
        grant_o  = GNT_M0;
        s_cyc_o  = m0_cyc_i & ~w_timeout;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i & ~w_timeout;
        m0_err_o = w_timeout;
        // An ack while the other master waits hands the bus back through idle.
        if (w_timeout || !m0_cyc_i || (s_ack_i && m1_cyc_i)) w_next = ST_IDLE;
      end
      ST_GRANT1: begin
        grant_o  = GNT_M1;
        s_cyc_o  = m1_cyc_i & ~w_timeout;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i & ~w_timeout;
        m1_err_o = w_timeout;
        if (w_timeout || !m1_cyc_i || (s_ack_i && m0_cyc_i)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed boundary cases, then random two-master
// traffic against a rule-level arbitration model and per-master scoreboards.
module tb_bus_arbiter;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_cyc_i, m0_we_i, m1_cyc_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_we_o, s_ack_i;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_sel_i(m0_sel_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_sel_i(m1_sel_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          mon_en = 1'b0;
  logic [1:0]  mg;   // model: owner expected this cycle
  logic        ml;   // model: last served was master 1
  logic [1:0]  eg;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: checks each cycle against the arbitration rules, pops scoreboards on ack.
  initial begin
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        eg = mg;
        chk("grant", 72'(grant_o), 72'(eg));
        chk("ack0", 72'(m0_ack_o), 72'(s_ack_i && eg == 2'b01));
        chk("ack1", 72'(m1_ack_o), 72'(s_ack_i && eg == 2'b10));
        chk("err", 72'({m1_err_o, m0_err_o}), 72'(0));
        case (eg)
          2'b01: chk("sbus_m0", 72'({s_cyc_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}),
                     72'({m0_cyc_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i}));
          2'b10: chk("sbus_m1", 72'({s_cyc_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}),
                     72'({m1_cyc_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i}));
          default: chk("scyc_idle", 72'(s_cyc_o), 72'(0));
        endcase
        if (m0_ack_o) begin
          if (q0.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL ack0_unexpected: got ack with empty queue, required none");
          end else chk("rdata0", 72'(m0_dat_o), 72'(q0.pop_front()));
        end
        if (m1_ack_o) begin
          if (q1.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL ack1_unexpected: got ack with empty queue, required none");
          end else chk("rdata1", 72'(m1_dat_o), 72'(q1.pop_front()));
        end
        // Owner for next cycle from this cycle's requests.
        case (eg)
          2'b00: begin
            if (m0_cyc_i && m1_cyc_i) mg = ml ? 2'b01 : 2'b10;
            else if (m0_cyc_i)        mg = 2'b01;
            else if (m1_cyc_i)        mg = 2'b10;
            else                      mg = 2'b00;
            if (mg != 2'b00) ml = (mg == 2'b10);
          end
          2'b01: if (!m0_cyc_i || (s_ack_i && m1_cyc_i)) mg = 2'b00;
          default: if (!m1_cyc_i || (s_ack_i && m0_cyc_i)) mg = 2'b00;
        endcase
      end
    end
  end

  task automatic issue(input int n);
    logic [31:0] a, d;
    logic        w;
    logic [3:0]  s;
    a = $urandom; d = $urandom;
    w = 1'($urandom_range(0, 1));
    s = 4'($urandom_range(1, 15));
    if (n == 0) begin
      m0_adr_i = a; m0_dat_i = d; m0_we_i = w; m0_sel_i = s; q0.push_back(rdata(a));
    end else begin
      m1_adr_i = a; m1_dat_i = d; m1_we_i = w; m1_sel_i = s; q1.push_back(rdata(a));
    end
  endtask

  initial begin
    int  rem[2];
    bit  act[2];
    bit  ackp[2];
    int  wcnt, wdly, cyc;
    rst_ni = 1'b0;
    m0_cyc_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_ack_i = 0; s_dat_i = '0;

    // Reset holds the bus idle even with a pending request.
    m0_cyc_i = 1;
    repeat (2) tick();
    chk("rst_grant", 72'(grant_o), 72'(2'b00));
    chk("rst_scyc", 72'(s_cyc_o), 72'(0));
    chk("rst_ack_err", 72'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 72'(0));
    rst_ni = 1'b1;
    #1 chk("idle_before_edge", 72'(grant_o), 72'(2'b00));
    tick();
    chk("post_rst_grant", 72'(grant_o), 72'(2'b01));
    chk("latency_scyc", 72'(s_cyc_o), 72'(1));

    // cyc falls in the same cycle as ack: ack still delivered, then idle.
    m0_cyc_i = 0; s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("drop_ack0", 72'(m0_ack_o), 72'(1));
    chk("drop_dat0", 72'(m0_dat_o), 72'(32'hDEAD_BEEF));
    chk("drop_ack1", 72'(m1_ack_o), 72'(0));
    tick();
    s_ack_i = 0;
    chk("drop_idle", 72'(grant_o), 72'(2'b00));

    // Tie after m0 served goes to m1; reset mid-grant forces idle at once.
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick();
    chk("tie_m1", 72'(grant_o), 72'(2'b10));
    rst_ni = 1'b0;
    #1;
    chk("midrst_scyc", 72'(s_cyc_o), 72'(0));
    chk("midrst_grant", 72'(grant_o), 72'(2'b00));
    tick();
    rst_ni = 1'b1;
    tick();
    chk("tie_after_rst_m0", 72'(grant_o), 72'(2'b01));

    // Slave never acks.
    m1_cyc_i = 0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      chk("to_noerr", 72'({m0_err_o, s_cyc_o}), 72'(2'b01));
      tick();
    end
    chk("to_err", 72'({m0_err_o, m1_err_o, s_cyc_o, m0_ack_o}), 72'(4'b1000));
    tick();
    chk("to_idle", 72'({grant_o, m0_err_o}), 72'(3'b000));
`else
    for (int k = 0; k < 8; k++) begin
      chk("noto_err", 72'({m0_err_o, m1_err_o}), 72'(0));
      chk("noto_grant", 72'(grant_o), 72'(2'b01));
      tick();
    end
`endif
    m0_cyc_i = 0;

    // Random traffic phase.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    mg = 2'b00; ml = 1'b1; mon_en = 1'b1;
    rem[0] = 60; rem[1] = 60;
    act[0] = 0; act[1] = 0; ackp[0] = 0; ackp[1] = 0;
    wcnt = 0; wdly = $urandom_range(0, 3);
    cyc = 0;
    while (cyc < 20000 && (rem[0] != 0 || rem[1] != 0 || act[0] || act[1])) begin
      cyc++;
      @(posedge clk_i);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (act[n] && ackp[n]) act[n] = 0;
        if (!act[n] && rem[n] > 0 && $urandom_range(0, 2) != 0) begin
          act[n] = 1; rem[n]--; issue(n);
        end
      end
      m0_cyc_i = act[0];
      m1_cyc_i = act[1];
      #1;
      if (s_cyc_o) begin
        if (wcnt >= wdly) begin
          s_ack_i = 1; s_dat_i = rdata(s_adr_o); wcnt = 0; wdly = $urandom_range(0, 3);
        end else begin
          s_ack_i = 0; s_dat_i = $urandom; wcnt++;
        end
      end else begin
        s_ack_i = 0; s_dat_i = $urandom; wcnt = 0;
      end
      @(negedge clk_i);
      ackp[0] = m0_ack_o;
      ackp[1] = m1_ack_o;
    end
    if (cyc >= 20000) begin
      n_chk++; n_err++;
      $display("FAIL traffic_budget: got unfinished traffic, required completion in 20000 cycles");
    end
    m0_cyc_i = 0; m1_cyc_i = 0; s_ack_i = 0;
    repeat (3) tick();
    mon_en = 1'b0;
    chk("q0_drained", 72'(q0.size()), 72'(0));
    chk("q1_drained", 72'(q1.size()), 72'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
